// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, zero-register index and types for the 32x64 register file
package regfile_pkg;
  localparam int WIDTH    = 64;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;
  typedef logic [WIDTH-1:0] word_t;
  typedef logic [4:0]       reg_addr_t;
endpackage

// File: rtl/reg_word.sv
// reg_word: WIDTH-bit enabled register with asynchronous active-low clear
module reg_word
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  en,
  input  word_t d,
  output word_t q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/regfile_32x64.sv
// regfile_32x64: 32x64 register file, XZR hardwired zero, 2 async reads, one-hot write, sticky multi-hot flag
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_32x64
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REGS-1:0] wr_onehot,
  input  word_t               wr_data,
  input  reg_addr_t           rd_addr_a,
  input  reg_addr_t           rd_addr_b,
  output word_t               rd_data_a,
  output word_t               rd_data_b,
  output logic                onehot_err
);
  word_t               regs [NUM_REGS];
  logic                multi;
  logic [ZERO_REG-1:0] wr_en;
  assign multi = $countones(wr_onehot) > 1;
  assign wr_en = multi ? '0 : wr_onehot[ZERO_REG-1:0];
  assign regs[ZERO_REG] = '0;
  for (genvar i = 0; i < ZERO_REG; i++) begin : g_reg
    reg_word u_word (.clk(clk), .reset_n(reset_n), .en(wr_en[i]), .d(wr_data), .q(regs[i]));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) onehot_err <= 1'b0;
    else if (multi) onehot_err <= 1'b1;
`ifdef REGFILE_BYPASS_EN
  logic byp_a, byp_b;
  // wr_en excludes X31 and is all-zero on multi-hot, so it alone qualifies the bypass
  assign byp_a = rd_addr_a != reg_addr_t'(ZERO_REG) && wr_en[rd_addr_a];
  assign byp_b = rd_addr_b != reg_addr_t'(ZERO_REG) && wr_en[rd_addr_b];
  assign rd_data_a = byp_a ? wr_data : regs[rd_addr_a];
  assign rd_data_b = byp_b ? wr_data : regs[rd_addr_b];
`else
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
`endif
endmodule

// File: tb/tb_regfile_32x64.sv
// tb_regfile_32x64: randomized and directed checks of regfile_32x64 against an array model
module tb_regfile_32x64;
  import regfile_pkg::*;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] wr_onehot = '0;
  word_t       wr_data = '0;
  reg_addr_t   rd_addr_a = '0;
  reg_addr_t   rd_addr_b = '0;
  word_t       rd_data_a, rd_data_b;
  logic        onehot_err;
  int          errors = 0;
  int          checks = 0;
  word_t       model [32];
  bit          err_m = 1'b0;

  regfile_32x64 dut (
    .clk(clk), .reset_n(reset_n), .wr_onehot(wr_onehot), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .onehot_err(onehot_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic word_t expect_rd(input reg_addr_t a);
    if (a == 5'd31) return '0;
`ifdef REGFILE_BYPASS_EN
    if ($countones(wr_onehot) == 1 && wr_onehot[a]) return wr_data;
`endif
    return model[a];
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
    err_m = 1'b0;
  endfunction

  task automatic cycle(input logic [31:0] oh, input word_t d, input reg_addr_t a, input reg_addr_t b);
    @(negedge clk);
    wr_onehot = oh; wr_data = d; rd_addr_a = a; rd_addr_b = b;
    #1;
    check("rd_a", rd_data_a, expect_rd(a));
    check("rd_b", rd_data_b, expect_rd(b));
    check("err", word_t'(onehot_err), word_t'(err_m));
    @(posedge clk);
    if ($countones(oh) > 1) err_m = 1'b1;
    else for (int k = 0; k < 31; k++) if (oh[k]) model[k] = d;
  endtask

  task automatic reset_sweep();
    @(negedge clk);
    #2 reset_n = 1'b0;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    wr_onehot = '0;
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = reg_addr_t'(i); rd_addr_b = reg_addr_t'(31 - i);
      #1;
      check("rst_a", rd_data_a, '0);
      check("rst_b", rd_data_b, '0);
    end
    check("rst_err", word_t'(onehot_err), '0);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] oh;
    int r, b0, b1;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    check("por_err", word_t'(onehot_err), '0);
    reset_n = 1'b1;
    // basic write/read, XZR write, same-cycle read of pending write
    cycle(32'd1 << 5, 64'hDEAD_BEEF_0123_4567, 5, 6);
    cycle('0, '0, 5, 6);
    check("x5_const", rd_data_a, 64'hDEAD_BEEF_0123_4567);
    check("x6_const", rd_data_b, '0);
    cycle(32'd1 << 31, '1, 31, 31);
    cycle('0, '0, 31, 31);
    check("x31_const", rd_data_a, '0);
    cycle(32'd1 << 7, 64'hA5, 7, 7);
    cycle('0, '0, 7, 7);
    check("x7_const", rd_data_a, 64'hA5);
    // random traffic including occasional multi-hot
    repeat (300) begin
      r = $urandom_range(0, 19);
      b0 = $urandom_range(0, 31);
      if (r == 0) oh = '0;
      else if (r == 1) oh = 32'd1 << 31;
      else if (r == 2) begin
        b1 = (b0 + $urandom_range(1, 31)) % 32;
        oh = (32'd1 << b0) | (32'd1 << b1);
      end else oh = 32'd1 << b0;
      cycle(oh, {$urandom, $urandom}, reg_addr_t'($urandom_range(0, 31)), reg_addr_t'($urandom_range(0, 31)));
    end
    reset_sweep();
    // multi-hot leaves registers untouched and sticks until reset
    cycle(32'd1 << 2, 64'h11, 2, 3);
    cycle(32'd1 << 3, 64'h22, 2, 3);
    cycle(32'h0000_000C, 64'h99, 2, 3);
    cycle(32'd1 << 4, 64'h55, 2, 3);
    check("x2_keep", rd_data_a, 64'h11);
    check("x3_keep", rd_data_b, 64'h22);
    cycle('0, '0, 4, 4);
    check("err_sticky", word_t'(onehot_err), 64'h1);
    // reset asserted mid-cycle with a write pending
    @(negedge clk);
    wr_onehot = 32'd1 << 9; wr_data = 64'h77;
    #2 reset_n = 1'b0;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    wr_onehot = '0;
    reset_n = 1'b1;
    cycle('0, '0, 9, 9);
    check("x9_discard", rd_data_a, '0);
    cycle(32'd1 << 9, 64'h1234, 9, 31);
    cycle('0, '0, 9, 9);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
